// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared direction codes and decode helpers for the up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Out-of-range load values clamp to the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulo);
        return (val < modulo) ? val : (modulo - 1);
    endfunction

    function automatic logic is_terminal(input int unsigned q,
                                         input logic        up,
                                         input int unsigned modulo);
        return (up == DIR_DOWN) ? (q == 0) : (q == modulo - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_next_calc.sv
// ============================================================================
// Module      : counter_next_calc
// Description : Combinational next-state for the counter: q, wrap and sat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_sat,
    input  logic             i_up,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_wrap_next,
    output logic             o_sat_next
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] w_clamped;
    logic             w_at_end;

    assign w_clamped = WIDTH'(clamp_load(32'(i_load_val), MODULO));
    assign w_at_end  = (i_up == DIR_UP) ? (i_q == c_max) : (i_q == '0);

    always_comb begin
        o_q_next    = i_q;
        o_wrap_next = 1'b0;
        o_sat_next  = i_sat;
        if (i_clr) begin
            o_q_next   = '0;
            o_sat_next = 1'b0;
        end else if (i_load) begin
            o_q_next   = w_clamped;
            o_sat_next = 1'b0;
        end else if (i_en) begin
            if (!w_at_end) begin
                o_q_next   = (i_up == DIR_UP) ? (i_q + c_one) : (i_q - c_one);
                o_sat_next = 1'b0;
            end else if (SATURATE != 0) begin
                o_sat_next = 1'b1;
            end else begin
                // Wrap to the opposite end of the range.
                o_q_next    = (i_up == DIR_UP) ? '0 : c_max;
                o_wrap_next = 1'b1;
                o_sat_next  = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/param_updown_counter.sv
// ============================================================================
// Module      : param_updown_counter
// Description : Parametrised synchronous up/down counter with modulus, load,
//               clear, enable, optional saturation and cascade terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_sat;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_sat_next;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MODULO   (MODULO),
        .SATURATE (SATURATE)
    ) u_next (
        .i_q         (r_q),
        .i_sat       (r_sat),
        .i_up        (up),
        .i_en        (en),
        .i_load      (load),
        .i_clr       (clr),
        .i_load_val  (load_val),
        .o_q_next    (w_q_next),
        .o_wrap_next (w_wrap_next),
        .o_sat_next  (w_sat_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
            r_sat  <= w_sat_next;
        end
    end

    // Unregistered so the next stage's enable lines up with this stage's wrap edge.
    assign tc   = en & is_terminal(32'(r_q), up, MODULO);
    assign q    = r_q;
    assign wrap = r_wrap;
    assign sat  = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_param_updown_counter.sv
// ============================================================================
// Module      : tb_param_updown_counter
// Description : Directed and random checks of wrapping, saturating and
//               cascaded counter instances against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_updown_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en_c = 1'b0;
    logic       one = 1'b1, zero = 1'b0;
    logic [3:0] zero4 = 4'd0;

    logic [3:0] q_w, q_s, q_c0, q_c1;
    logic       tc_w, tc_s, tc_c0, tc_c1;
    logic       wrap_w, wrap_s, wrap_c0, wrap_c1;
    logic       sat_w, sat_s, sat_c0, sat_c1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index 0 = wrapping instance, 1 = saturating instance.
    int m_q[2];
    bit m_wrap[2];
    bit m_sat[2];
    int cnt;
    bit cw0, cw1;
    int c1_pulses;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MODULO(M), .SATURATE(0)) u_w (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q_w), .tc(tc_w), .wrap(wrap_w), .sat(sat_w));

    param_updown_counter #(.WIDTH(4), .MODULO(M), .SATURATE(1)) u_s (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s));

    param_updown_counter #(.WIDTH(4), .MODULO(M), .SATURATE(0)) u_c0 (
        .clk(clk), .reset(reset), .clr(zero), .en(en_c), .up(one), .load(zero),
        .load_val(zero4), .q(q_c0), .tc(tc_c0), .wrap(wrap_c0), .sat(sat_c0));

    param_updown_counter #(.WIDTH(4), .MODULO(M), .SATURATE(0)) u_c1 (
        .clk(clk), .reset(reset), .clr(zero), .en(tc_c0), .up(one), .load(zero),
        .load_val(zero4), .q(q_c1), .tc(tc_c1), .wrap(wrap_c1), .sat(sat_c1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
        end
        cnt = 0; cw0 = 0; cw1 = 0;
    endtask

    // Step rule: move by +/-1; leaving 0..M-1 either wraps modulo M or holds.
    task automatic model_edge();
        int nxt;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 0;
            if (clr) begin
                m_q[i] = 0; m_sat[i] = 0;
            end else if (load) begin
                m_q[i] = (int'(load_val) < M) ? int'(load_val) : M - 1;
                m_sat[i] = 0;
            end else if (en) begin
                nxt = up ? m_q[i] + 1 : m_q[i] - 1;
                if (nxt >= 0 && nxt < M) begin
                    m_q[i] = nxt; m_sat[i] = 0;
                end else if (i == 1) begin
                    m_sat[i] = 1;
                end else begin
                    m_q[i] = (nxt + M) % M; m_wrap[i] = 1;
                end
            end
        end
        if (en_c) begin
            cnt = (cnt + 1) % (M * M);
            cw0 = (cnt % M == 0);
            cw1 = (cnt == 0);
        end else begin
            cw0 = 0; cw1 = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".q_w"},    q_w,    m_q[0]);
        chk({tag, ".wrap_w"}, wrap_w, m_wrap[0]);
        chk({tag, ".sat_w"},  sat_w,  1'b0);
        chk({tag, ".q_s"},    q_s,    m_q[1]);
        chk({tag, ".wrap_s"}, wrap_s, 1'b0);
        chk({tag, ".sat_s"},  sat_s,  m_sat[1]);
        chk({tag, ".q_c"},    {q_c1, q_c0}, {4'(cnt / M), 4'(cnt % M)});
        chk({tag, ".wrap_c0"}, wrap_c0, cw0);
        chk({tag, ".wrap_c1"}, wrap_c1, cw1);
    endtask

    task automatic check_tc(input string tag);
        bit t0;
        chk({tag, ".tc_w"}, tc_w, en & (up ? m_q[0] == M - 1 : m_q[0] == 0));
        chk({tag, ".tc_s"}, tc_s, en & (up ? m_q[1] == M - 1 : m_q[1] == 0));
        t0 = en_c & (cnt % M == M - 1);
        chk({tag, ".tc_c0"}, tc_c0, t0);
        chk({tag, ".tc_c1"}, tc_c1, t0 & (cnt / M == M - 1));
    endtask

    task automatic cycle(input string tag, input bit c, input bit l, input bit e,
                         input bit u, input logic [3:0] lv, input bit ec);
        clr = c; load = l; en = e; up = u; load_val = lv; en_c = ec;
        #1;
        check_tc(tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        if (wrap_c1) c1_pulses++;
    endtask

    initial begin
        model_reset();
        c1_pulses = 0;

        // Reset state, held over an edge.
        #2;
        check_outputs("reset");
        cycle("reset_hold", 0, 0, 1, 1, 4'd0, 1);
        reset = 1'b1;

        // Count up 0..9 then wrap, and one step beyond.
        for (int i = 0; i < 11; i++) cycle("up", 0, 0, 1, 1, 4'd0, 0);

        // Clear, then count down through the 0 -> 9 wrap.
        cycle("clr", 1, 0, 1, 1, 4'd0, 0);
        for (int i = 0; i < 11; i++) cycle("down", 0, 0, 1, 0, 4'd0, 0);

        // Load clamp and load-over-enable priority.
        cycle("load12", 0, 1, 0, 1, 4'd12, 0);
        chk("load12.clamp", q_w, 4'd9);
        cycle("load3_en", 0, 1, 1, 1, 4'd3, 0);
        chk("load3_en.q", q_w, 4'd3);

        // Saturation at the top end, then release by reversing.
        cycle("load7", 0, 1, 1, 1, 4'd7, 0);
        for (int i = 0; i < 4; i++) cycle("sat_up", 0, 0, 1, 1, 4'd0, 0);
        chk("sat_up.held", {q_s, sat_s}, {4'd9, 1'b1});
        cycle("sat_rev", 0, 0, 1, 0, 4'd0, 0);
        chk("sat_rev.q", {q_s, sat_s}, {4'd8, 1'b0});
        for (int i = 0; i < 10; i++) cycle("sat_dn", 0, 0, 1, 0, 4'd0, 0);
        cycle("sat_idle", 0, 0, 0, 0, 4'd0, 0);

        // Asynchronous reset between edges at q=5.
        cycle("load5", 0, 1, 0, 1, 4'd5, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async.q_w", q_w, 4'd0);
        chk("async.q_s", q_s, 4'd0);
        chk("async.q_c0", q_c0, 4'd0);
        cycle("async_hold", 0, 0, 1, 1, 4'd0, 1);
        reset = 1'b1;
        cycle("first_count", 0, 0, 1, 1, 4'd0, 0);
        chk("first_count.q", q_w, 4'd1);
        cycle("clr_load", 1, 1, 1, 1, 4'd6, 0);
        chk("clr_load.q", q_w, 4'd0);

        // Randomised mix of all controls.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom % 16) == 0, ($urandom % 8) == 0,
                  ($urandom % 4) != 0, $urandom % 2, 4'($urandom % 16),
                  $urandom % 2);
        end

        // Cascade: 100 enabled cycles from 00 return to 00 with one upper wrap.
        reset = 1'b0;
        #1;
        model_reset();
        cycle("casc_rst", 0, 0, 0, 1, 4'd0, 0);
        reset = 1'b1;
        c1_pulses = 0;
        for (int i = 0; i < 100; i++) cycle("casc", 0, 0, 0, 1, 4'd0, 1);
        chk("casc.final_q", {q_c1, q_c0}, 8'h00);
        chk("casc.c1_pulses", c1_pulses, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
